// File: rtl/multi_servo_pwm.sv
// Multi-channel hobby-servo PWM generator.
// One shared frame counter drives CHANNELS registered pulse outputs. Position codes
// are written into shadow registers and committed to the active set at the frame
// boundary, so a pulse width never changes inside a frame.
// Optional feature macro: SERVO_SLEW_EN -- limits the per-frame change of each
// active position to SLEW_STEP codes.
module multi_servo_pwm #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned POS_W     = 8,
  parameter int unsigned PERIOD_US = 20000,
  parameter int unsigned MIN_US    = 500,
  parameter int unsigned MAX_US    = 2500,
  parameter int unsigned SLEW_STEP = 4,
  localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                Main_clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [POS_W-1:0]    wr_pos,
  output logic                wr_err,
  output logic                frame_start,
  output logic [CHANNELS-1:0] servo_pwm
);

  localparam int unsigned TPU          = CLK_HZ / 1_000_000;
  localparam int unsigned PERIOD_TICKS = PERIOD_US * TPU;
  localparam int unsigned MIN_TICKS    = MIN_US * TPU;
  localparam int unsigned POS_MAX      = (1 << POS_W) - 1;
  localparam int unsigned STEP         = ((MAX_US - MIN_US) * TPU) / POS_MAX;
  localparam int unsigned MAX_ON       = MIN_TICKS + POS_MAX * STEP;
  localparam int unsigned CNT_W        = $clog2(PERIOD_TICKS);
  localparam int unsigned ON_W         = $clog2(MAX_ON + 1);
  localparam int unsigned CMP_W        = (CNT_W > ON_W) ? CNT_W : ON_W;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_TICKS - 1);
  localparam logic [POS_W-1:0] CENTRE   = POS_W'(1 << (POS_W - 1));
  localparam logic [CH_W:0]    CH_LIM   = (CH_W + 1)'(CHANNELS);

  // Elaboration-time parameter sanity checks
  if (CLK_HZ % 1_000_000 != 0 || TPU == 0) begin : g_bad_clk
    $error("multi_servo_pwm: CLK_HZ must be a non-zero multiple of 1 MHz");
  end
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_ch
    $error("multi_servo_pwm: CHANNELS must be 1..16");
  end
  if (SLEW_STEP < 1 || SLEW_STEP > POS_MAX) begin : g_bad_slew
    $error("multi_servo_pwm: SLEW_STEP must be 1..2**POS_W-1");
  end

  logic [CNT_W-1:0] cnt;
  logic             restart_q;
  logic [POS_W-1:0] shadow_pos  [CHANNELS];
  logic [POS_W-1:0] active_pos  [CHANNELS];
  logic [POS_W-1:0] next_active [CHANNELS];
  logic [ON_W-1:0]  on_ticks    [CHANNELS];
  logic             commit_c;
  logic             wr_valid_c;

  // Commit on the last tick of a frame, or on the first enabled tick after reset/disable
  assign commit_c   = enable & (restart_q | (cnt == CNT_LAST));
  assign wr_valid_c = ({1'b0, wr_ch} < CH_LIM);

`ifdef SERVO_SLEW_EN
  localparam logic [POS_W-1:0] SLEW_P = POS_W'(SLEW_STEP);

  // Move each active position toward its shadow by at most SLEW_P, landing exactly
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      next_active[i] = shadow_pos[i];
      if (shadow_pos[i] > active_pos[i]) begin
        if ((shadow_pos[i] - active_pos[i]) > SLEW_P) begin
          next_active[i] = active_pos[i] + SLEW_P;
        end
      end else begin
        if ((active_pos[i] - shadow_pos[i]) > SLEW_P) begin
          next_active[i] = active_pos[i] - SLEW_P;
        end
      end
    end
  end
`else
  // Commit takes the shadow value directly
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      next_active[i] = shadow_pos[i];
    end
  end
`endif

  // Linear position-to-width mapping; ON_W is sized for the full-scale code
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      on_ticks[i] = ON_W'(MIN_TICKS) + ON_W'(active_pos[i]) * ON_W'(STEP);
    end
  end

  // Frame counter, frame/write status pulses and pulse outputs
  always_ff @(posedge Main_clock) begin
    if (reset) begin
      cnt         <= '0;
      restart_q   <= 1'b1;
      frame_start <= 1'b0;
      wr_err      <= 1'b0;
      servo_pwm   <= '0;
    end else begin
      wr_err      <= wr_en & ~wr_valid_c;
      frame_start <= enable & (cnt == '0);
      if (enable) begin
        cnt       <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        restart_q <= 1'b0;
      end else begin
        cnt       <= '0;
        restart_q <= 1'b1;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        servo_pwm[i] <= enable & (CMP_W'(cnt) < CMP_W'(on_ticks[i]));
      end
    end
  end

  // Shadow writes and frame-boundary commit into the active set
  always_ff @(posedge Main_clock) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_pos[i] <= CENTRE;
        active_pos[i] <= CENTRE;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_en && wr_valid_c && (wr_ch == CH_W'(i))) begin
          shadow_pos[i] <= wr_pos;
        end
        if (commit_c) begin
          active_pos[i] <= next_active[i];
        end
      end
    end
  end

endmodule
